fetch_unit: RTL

- Instruction fetch stage of the RV32E core: owns the architectural fetch PC, issues word requests to instruction memory, and buffers returned instructions for decode.
- Consumes the brancher's registered outputs (branch_taken, branch_addr) to redirect fetch.
- On a redirect it flushes buffered and in-flight wrong-path instructions.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32E instruction fetch: owns the fetch PC, issues word requests and
// buffers returned instructions for decode, flushing wrong-path work on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_U = (CW+1)'(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ipc_q [BUF_DEPTH];
  logic [AW-1:0] iwr_q, ird_q;
  logic [CW-1:0] osd_q, osd_d;
  logic [CW-1:0] drop_q, drop_d;
  ent_t          ibuf_q [BUF_DEPTH];
  logic [AW-1:0] bwr_q, brd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          acc, rsp, keep, pop;
  logic [CW:0]   used;

  assign used     = {1'b0, cnt_q} + {1'b0, osd_q};
  assign imem_req = !rst && (used < DEPTH_U);
  assign imem_addr = pc_q;
  assign acc      = imem_req && imem_ready;
  // A response with nothing in flight cannot belong to us.
  assign rsp      = imem_rvalid && (osd_q != '0);
  assign keep     = rsp && (drop_q == '0) && !branch_taken;

  assign instr_valid = (cnt_q != '0) && !branch_taken;
  assign instr       = ibuf_q[brd_q].data;
  assign instr_pc    = ibuf_q[brd_q].pc;
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    osd_d  = osd_q + CW'(acc) - CW'(rsp);
    if (acc)
      pc_d = pc_q + 32'd4;
    if (branch_taken) begin
      pc_d   = branch_addr & 32'hFFFF_FFFC;
      // Everything still in flight after this cycle is wrong-path.
      drop_d = osd_d;
      cnt_d  = '0;
    end else begin
      if (rsp && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      cnt_d = cnt_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      osd_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      iwr_q  <= '0;
      ird_q  <= '0;
      bwr_q  <= '0;
      brd_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        ipc_q[i]  <= '0;
        ibuf_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      osd_q  <= osd_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      if (acc) begin
        ipc_q[iwr_q] <= pc_q;
        iwr_q        <= iwr_q + AW'(1);
      end
      if (rsp)
        ird_q <= ird_q + AW'(1);
      if (branch_taken) begin
        bwr_q <= '0;
        brd_q <= '0;
      end else begin
        if (keep) begin
          ibuf_q[bwr_q] <= {imem_rdata, ipc_q[ird_q]};
          bwr_q         <= bwr_q + AW'(1);
        end
        if (pop)
          brd_q <= brd_q + AW'(1);
      end
    end
  end

  a_osd_cap: assert property (@(posedge clk) disable iff (rst)
    osd_q <= CW'(BUF_DEPTH));
  a_drop_cap: assert property (@(posedge clk) disable iff (rst)
    drop_q <= osd_q);
  a_credit: assert property (@(posedge clk) disable iff (rst)
    used <= DEPTH_U);

endmodule
